// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the shared LED bank with a minimum ownership time before pre-emption.
// Optional LED_ARB_PRIO_EN: requester 0 is urgent and pre-empts any other owner regardless of hold.
module led_bank_arbiter #(
  parameter int             NREQ     = 4,
  parameter int             W        = 16,
  parameter int             HOLD     = 1000,
  parameter logic [W-1:0]   IDLE_VAL = {W{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       data,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy,
  output logic [W-1:0]            ledr
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_HANDOFF = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic [W-1:0]    ledr_q, ledr_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [OW-1:0]   pick_s;
  logic [OW-1:0]   nxt_ptr_s;
  logic [NREQ-1:0] others_s;
  logic            urgent_s;
  logic            release_s;
  logic [W-1:0]    owner_data_s;

  // First requester at or after ptr, wrapping; lowest offset wins.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
    logic [OW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (r[idx]) begin
        pick = OW'(idx);
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  assign owner_data_s = data[owner_q*W +: W];
  assign nxt_ptr_s    = (owner_q == OW'(NREQ - 1)) ? {OW{1'b0}} : owner_q + OW'(1);

  always_comb begin
`ifdef LED_ARB_PRIO_EN
    if (req[0]) begin
      pick_s = {OW{1'b0}};
    end else begin
      pick_s = rr_pick(req, rr_q);
    end
    urgent_s = (owner_q != {OW{1'b0}}) & req[0];
`else
    pick_s   = rr_pick(req, rr_q);
    urgent_s = 1'b0;
`endif
    others_s  = req & ~gnt_q;
    release_s = ~req[owner_q] | ((hold_q == {HW{1'b0}}) & (|others_s)) | urgent_s;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    ledr_d  = IDLE_VAL;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          owner_d = pick_s;
          busy_d  = 1'b1;
          hold_d  = HW'(HOLD - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (release_s) begin
          state_d = S_HANDOFF;
          gnt_d   = {NREQ{1'b0}};
          busy_d  = 1'b0;
          rr_d    = nxt_ptr_s;
        end else begin
          ledr_d = owner_data_s;
          hold_d = (hold_q == {HW{1'b0}}) ? {HW{1'b0}} : hold_q - HW'(1);
        end
      end
      S_HANDOFF: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = {NREQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= {NREQ{1'b0}};
      owner_q <= {OW{1'b0}};
      busy_q  <= 1'b0;
      ledr_q  <= IDLE_VAL;
      rr_q    <= {OW{1'b0}};
      hold_q  <= {HW{1'b0}};
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      ledr_q  <= ledr_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign ledr  = ledr_q;

endmodule
